button_conditioner: RTL

//   Conditions one raw push-button input (e.g. the manual-clock button feeding gray_counter i_man_clk).

---
 rtl/button_conditioner.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: conditions one raw push-button input.
//   Synchronises the raw pin, debounces it and produces a registered level
//   plus single-cycle press/release strobes. While the button is held the
//   press strobe can optionally auto-repeat after an initial delay.
//
// Ports:
//   i_clk      in   system clock
//   i_rst      in   synchronous reset, active-high
//   i_btn      in   raw asynchronous button, 1 = pressed
//   o_level    out  debounced button state
//   o_pulse    out  1-cycle strobe on debounced press and each auto-repeat
//   o_release  out  1-cycle strobe on debounced release
module button_conditioner #(
    parameter int unsigned DEFAULT_FREQ_HZ = 100_000_000,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_release
);

    // Cycle counts are computed in 64 bits so large clock rates cannot overflow.
    localparam longint unsigned DB_CYC =
        (64'(DEFAULT_FREQ_HZ) * 64'(DEBOUNCE_MS)) / 64'd1000;
    localparam longint unsigned RD_CYC =
        (64'(DEFAULT_FREQ_HZ) * 64'(REPEAT_DELAY_MS)) / 64'd1000;
    localparam longint unsigned RR_CYC =
        (64'(DEFAULT_FREQ_HZ) * 64'(REPEAT_RATE_MS)) / 64'd1000;

    localparam longint unsigned MAX_AB  = (DB_CYC > RD_CYC) ? DB_CYC : RD_CYC;
    localparam longint unsigned MAX_CYC = (MAX_AB > RR_CYC) ? MAX_AB : RR_CYC;
    localparam int unsigned     CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 64'd1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 64'd1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYC - 64'd1);

    if (DB_CYC < 1) begin : gen_db_chk
        $error("button_conditioner: debounce cycle count must be >= 1");
    end
    if (RD_CYC < 1) begin : gen_rd_chk
        $error("button_conditioner: repeat delay cycle count must be >= 1");
    end
    if (RR_CYC < 1) begin : gen_rr_chk
        $error("button_conditioner: repeat rate cycle count must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : gen_sync_chk
        $error("button_conditioner: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StHeld,
        StRpt,
        StDbRel
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   release_q, release_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Saturate so a long hold with repeat disabled never wraps the counter.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_btn};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync) begin
                    state_d = StDbPress;
                    cnt_d   = '0;
                end
            end
            StDbPress: begin
                if (!sync) begin
                    // Glitch shorter than the debounce window: drop silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end
            end
            StHeld: begin
                if (!sync) begin
                    state_d = StDbRel;
                    cnt_d   = '0;
                end else if ((REPEAT_EN != 0) && (cnt_q == RD_LAST)) begin
                    state_d = StRpt;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end
            end
            StRpt: begin
                if (!sync) begin
                    state_d = StDbRel;
                    cnt_d   = '0;
                end else if (cnt_q == RR_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end
            end
            StDbRel: begin
                if (sync) begin
                    // Release bounce: back to held, repeat delay starts over.
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_pulse   = pulse_q;
    assign o_release = release_q;

endmodule
